// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and
// the instruction memory. The fetch stage is the master (drives req/addr),
// the memory is the slave (drives ack/rdata).
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues word-aligned fetches on the imem bus, presents one instruction per
// cycle downstream, holds on stall (with a one-entry skid buffer for a word
// that lands during a stall) and restarts fetch on redirect. A request that
// is still in flight when a redirect arrives is completed and its data
// dropped (DISCARD state) so the bus handshake is never broken.
// Optional macro IF_STAGE_PERF_CNT_EN adds delivered-instruction and
// stall-cycle counters; without it the perf outputs read zero.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;          // current fetch address, also drives imem.addr
  logic [31:0] target_r;      // pending redirect target while discarding
  logic        outstanding_r; // request was raised and not yet acked
  logic        skid_valid_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_insn_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_insn_r;
  logic        if_valid_r;

  logic        req_s;
  logic        xfer_s;
  logic        fetch_xfer_s;
  logic [31:0] redirect_aligned_s;

  // Request generation: an in-flight request is always held until acked;
  // a new one starts only when nothing downstream is blocking.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      IDLE:    req_s = 1'b0;
      FETCH:   req_s = outstanding_r | (~stall & ~skid_valid_r);
      DISCARD: req_s = outstanding_r;
      default: req_s = 1'b0;
    endcase
  end

  assign xfer_s             = req_s & imem.ack;
  assign fetch_xfer_s       = xfer_s & (state_r == FETCH);
  assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

  assign imem.req  = req_s;
  assign imem.addr = pc_r;

  // Fetch FSM: tracks the fetch address, outstanding request and redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      target_r      <= RESET_PC;
      outstanding_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r       <= FETCH;
          outstanding_r <= 1'b0;
        end
        FETCH: begin
          if (redirect) begin
            if (req_s && !imem.ack) begin
              // keep address stable until the in-flight word comes back
              state_r       <= DISCARD;
              target_r      <= redirect_aligned_s;
              outstanding_r <= 1'b1;
            end else begin
              pc_r          <= redirect_aligned_s;
              outstanding_r <= 1'b0;
            end
          end else if (xfer_s) begin
            pc_r          <= pc_r + 32'd4;
            outstanding_r <= 1'b0;
          end else begin
            outstanding_r <= req_s;
          end
        end
        DISCARD: begin
          if (xfer_s) begin
            state_r       <= FETCH;
            outstanding_r <= 1'b0;
            pc_r          <= redirect ? redirect_aligned_s : target_r;
          end else begin
            outstanding_r <= 1'b1;
            if (redirect) begin
              target_r <= redirect_aligned_s;
            end else begin
              target_r <= target_r;
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          outstanding_r <= 1'b0;
        end
      endcase
    end
  end

  // Downstream outputs and skid buffer: redirect flushes, stall holds, else deliver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc_r      <= RESET_PC;
      if_insn_r    <= NOP_INSN;
      if_valid_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= RESET_PC;
      skid_insn_r  <= NOP_INSN;
    end else if (redirect) begin
      if_valid_r   <= 1'b0;
      if_insn_r    <= NOP_INSN;
      skid_valid_r <= 1'b0;
    end else if (stall) begin
      if (fetch_xfer_s) begin
        skid_valid_r <= 1'b1;
        skid_pc_r    <= pc_r;
        skid_insn_r  <= imem.rdata;
      end else begin
        skid_valid_r <= skid_valid_r;
      end
    end else if (skid_valid_r) begin
      if_pc_r    <= skid_pc_r;
      if_insn_r  <= skid_insn_r;
      if_valid_r <= 1'b1;
      if (fetch_xfer_s) begin
        skid_pc_r   <= pc_r;
        skid_insn_r <= imem.rdata;
      end else begin
        skid_valid_r <= 1'b0;
      end
    end else if (fetch_xfer_s) begin
      if_pc_r    <= pc_r;
      if_insn_r  <= imem.rdata;
      if_valid_r <= 1'b1;
    end else begin
      if_valid_r <= 1'b0;
      if_insn_r  <= NOP_INSN;
    end
  end

  assign if_pc          = if_pc_r;
  assign if_instruction = if_insn_r;
  assign if_valid       = if_valid_r;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Performance counters: consumed instructions and stall cycles, free-running wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (if_valid_r && !stall) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (stall) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. Memory returns rdata = addr so
// every delivered instruction word identifies the address it came from.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int n_pass;
  int n_total;

  if_stage_if bus ();

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_valid       (if_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  assign bus.rdata = bus.addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bus.ack     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.req); else n_pass++;
    n_total++; if (bus.addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.addr); else n_pass++;
    n_total++; if (if_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", if_pc); else n_pass++;
    n_total++; if (if_instruction !== NOP) $display("FAIL rst_insn: got %h want %h", if_instruction, NOP); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", if_valid); else n_pass++;
    n_total++; if (perf_fetch_cnt !== 32'h0) $display("FAIL rst_pfc: got %h want 0", perf_fetch_cnt); else n_pass++;
    n_total++; if (perf_stall_cnt !== 32'h0) $display("FAIL rst_psc: got %h want 0", perf_stall_cnt); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    bus.ack = 1'b1;
    tick();
    n_total++; if (bus.req !== 1'b1) $display("FAIL stream_req: got %b want 1", bus.req); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL stream_v0: got %b want 0", if_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (if_valid !== 1'b1) $display("FAIL stream_valid%0d: got %b want 1", i, if_valid); else n_pass++;
      n_total++; if (if_pc !== 32'(i * 4)) $display("FAIL stream_pc%0d: got %h want %h", i, if_pc, 32'(i * 4)); else n_pass++;
      n_total++; if (if_instruction !== 32'(i * 4)) $display("FAIL stream_insn%0d: got %h want %h", i, if_instruction, 32'(i * 4)); else n_pass++;
    end
    n_total++; if (bus.addr !== 32'hC) $display("FAIL stream_addr: got %h want c", bus.addr); else n_pass++;
  endtask

  task automatic test_ack_delay();
    do_reset();
    bus.ack = 1'b1;
    repeat (3) tick();
    bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (bus.addr !== 32'h8) $display("FAIL dly_addr%0d: got %h want 8", i, bus.addr); else n_pass++;
      n_total++; if (if_valid !== 1'b0) $display("FAIL dly_valid%0d: got %b want 0", i, if_valid); else n_pass++;
      n_total++; if (if_instruction !== NOP) $display("FAIL dly_insn%0d: got %h want %h", i, if_instruction, NOP); else n_pass++;
      n_total++; if (if_pc !== 32'h4) $display("FAIL dly_pc%0d: got %h want 4", i, if_pc); else n_pass++;
    end
    bus.ack = 1'b1;
    tick();
    n_total++; if (if_valid !== 1'b1) $display("FAIL dly_valid_end: got %b want 1", if_valid); else n_pass++;
    n_total++; if (if_pc !== 32'h8) $display("FAIL dly_pc_end: got %h want 8", if_pc); else n_pass++;
  endtask

  task automatic test_stall_hold();
    do_reset();
    bus.ack = 1'b1;
    repeat (2) tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (if_valid !== 1'b1) $display("FAIL hold_valid%0d: got %b want 1", i, if_valid); else n_pass++;
      n_total++; if (if_pc !== 32'h0) $display("FAIL hold_pc%0d: got %h want 0", i, if_pc); else n_pass++;
      n_total++; if (bus.req !== 1'b0) $display("FAIL hold_req%0d: got %b want 0", i, bus.req); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++; if (if_pc !== 32'h4) $display("FAIL hold_resume: got %h want 4", if_pc); else n_pass++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    bus.ack = 1'b1;
    repeat (4) tick();
    bus.ack = 1'b0;
    tick();
    n_total++; if (bus.req !== 1'b1 || bus.addr !== 32'hC) $display("FAIL skid_out: got req=%b addr=%h want 1/c", bus.req, bus.addr); else n_pass++;
    stall = 1'b1;
    bus.ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (if_valid !== 1'b0 || if_pc !== 32'h8) $display("FAIL skid_hold%0d: got v=%b pc=%h want 0/8", i, if_valid, if_pc); else n_pass++;
      n_total++; if (bus.req !== 1'b0 || bus.addr !== 32'h10) $display("FAIL skid_req%0d: got req=%b addr=%h want 0/10", i, bus.req, bus.addr); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instruction !== 32'hC) $display("FAIL skid_drain: got v=%b pc=%h insn=%h want 1/c/c", if_valid, if_pc, if_instruction); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instruction !== 32'h10) $display("FAIL skid_next: got v=%b pc=%h insn=%h want 1/10/10", if_valid, if_pc, if_instruction); else n_pass++;
  endtask

  task automatic test_redirect_discard();
    do_reset();
    bus.ack = 1'b1;
    repeat (5) tick();
    bus.ack = 1'b0;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_total++; if (bus.req !== 1'b1 || bus.addr !== 32'h10) $display("FAIL disc_hold: got req=%b addr=%h want 1/10", bus.req, bus.addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0 || if_instruction !== NOP) $display("FAIL disc_bubble: got v=%b insn=%h want 0/%h", if_valid, if_instruction, NOP); else n_pass++;
    tick();
    n_total++; if (bus.addr !== 32'h10) $display("FAIL disc_wait: got %h want 10", bus.addr); else n_pass++;
    bus.ack = 1'b1;
    tick();
    n_total++; if (if_valid !== 1'b0 || if_instruction !== NOP) $display("FAIL disc_drop: got v=%b insn=%h want 0/%h", if_valid, if_instruction, NOP); else n_pass++;
    n_total++; if (bus.addr !== 32'h100) $display("FAIL disc_target: got %h want 100", bus.addr); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instruction !== 32'h100) $display("FAIL disc_resume: got v=%b pc=%h insn=%h want 1/100/100", if_valid, if_pc, if_instruction); else n_pass++;
  endtask

  task automatic test_discard_retarget();
    do_reset();
    bus.ack = 1'b1;
    repeat (2) tick();
    bus.ack = 1'b0;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n_total++; if (bus.addr !== 32'h4) $display("FAIL retgt_hold: got %h want 4", bus.addr); else n_pass++;
    bus.ack = 1'b1;
    tick();
    n_total++; if (bus.addr !== 32'h300) $display("FAIL retgt_addr: got %h want 300", bus.addr); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h300) $display("FAIL retgt_pc: got v=%b pc=%h want 1/300", if_valid, if_pc); else n_pass++;
  endtask

  task automatic test_redirect_same_ack();
    do_reset();
    bus.ack = 1'b1;
    repeat (2) tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    n_total++; if (if_valid !== 1'b0 || if_instruction !== NOP) $display("FAIL rsa_bubble: got v=%b insn=%h want 0/%h", if_valid, if_instruction, NOP); else n_pass++;
    n_total++; if (bus.addr !== 32'h40) $display("FAIL rsa_addr: got %h want 40", bus.addr); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instruction !== 32'h40) $display("FAIL rsa_resume: got v=%b pc=%h insn=%h want 1/40/40", if_valid, if_pc, if_instruction); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    do_reset();
    bus.ack = 1'b1;
    repeat (2) tick();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h203;
    tick();
    stall = 1'b0;
    redirect = 1'b0;
    n_total++; if (if_valid !== 1'b0 || if_instruction !== NOP) $display("FAIL rs_bubble: got v=%b insn=%h want 0/%h", if_valid, if_instruction, NOP); else n_pass++;
    n_total++; if (bus.addr !== 32'h200) $display("FAIL rs_addr: got %h want 200", bus.addr); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h200) $display("FAIL rs_resume: got v=%b pc=%h want 1/200", if_valid, if_pc); else n_pass++;
  endtask

  task automatic test_reset_midreq();
    do_reset();
    bus.ack = 1'b1;
    repeat (3) tick();
    bus.ack = 1'b0;
    reset = 1'b1;
    #2;
    n_total++; if (bus.req !== 1'b0 || bus.addr !== 32'h0) $display("FAIL arst_bus: got req=%b addr=%h want 0/0", bus.req, bus.addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0 || if_pc !== 32'h0) $display("FAIL arst_out: got v=%b pc=%h want 0/0", if_valid, if_pc); else n_pass++;
    bus.ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_total++; if (if_valid !== 1'b0 || bus.addr !== 32'h0) $display("FAIL arst_idle_ack: got v=%b addr=%h want 0/0", if_valid, bus.addr); else n_pass++;
    tick();
    n_total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) $display("FAIL arst_first: got v=%b pc=%h want 1/0", if_valid, if_pc); else n_pass++;
  endtask

  task automatic test_perf();
    logic [31:0] exp_f;
    logic [31:0] exp_s;
`ifdef IF_STAGE_PERF_CNT_EN
    exp_f = 32'd10;
    exp_s = 32'd3;
`else
    exp_f = 32'd0;
    exp_s = 32'd0;
`endif
    do_reset();
    bus.ack = 1'b1;
    repeat (2) tick();
    repeat (10) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    n_total++; if (perf_fetch_cnt !== exp_f) $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, exp_f); else n_pass++;
    n_total++; if (perf_stall_cnt !== exp_s) $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, exp_s); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_ack_delay();
    test_stall_hold();
    test_stall_skid();
    test_redirect_discard();
    test_discard_retarget();
    test_redirect_same_ack();
    test_redirect_stall();
    test_reset_midreq();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013: instruction driven on bubbles (addi x0,x0,0).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  downstream hold request.
REQ-006 redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-007 redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  word-aligned fetch address.
REQ-010 imem_ack  in  1  request accepted, imem_rdata valid this cycle.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 if_pc  out  32  PC of if_instruction, registered.
REQ-013 if_instruction  out  32  fetched instruction or NOP_INSN, registered.
REQ-014 if_valid  out  1  if_instruction is a real fetched instruction.
REQ-015 perf_fetch_cnt  out  32  delivered-instruction counter.
REQ-016 perf_stall_cnt  out  32  stall-cycle counter.

Function
REQ-017 Transfer occurs in any cycle with imem_req=1 and imem_ack=1; same-cycle ack is legal.
REQ-018 Once imem_req is asserted, imem_req and imem_addr are held stable until the transfer cycle.
REQ-019 FSM states: IDLE (first cycle after reset, imem_req=0), FETCH, DISCARD; IDLE->FETCH unconditionally.
REQ-020 FETCH: imem_req=1 when (no request outstanding, stall=0, skid empty) or a request is outstanding.
REQ-021 Transfer in FETCH without stall: next edge if_valid=1, if_pc=imem_addr, if_instruction=imem_rdata; fetch PC += 4 (wraps mod 2^32).
REQ-022 Latency ack->if_valid = 1 cycle; zero-wait memory sustains 1 instruction/cycle.
REQ-023 No transfer and stall=0: next edge if_valid=0, if_instruction=NOP_INSN, if_pc unchanged.
REQ-024 stall=1, redirect=0: if_pc/if_instruction/if_valid hold; no new request issued.
REQ-025 Transfer during stall=1: word+PC captured in 1-entry skid buffer; on first stall=0 cycle skid entry drives outputs next edge, skid empties.
REQ-026 redirect=1 has priority over stall: next edge if_valid=0, if_instruction=NOP_INSN, skid flushed, fetch PC <= redirect_pc.
REQ-027 redirect with request outstanding and no ack that cycle: FETCH->DISCARD; request held until ack, data dropped, then DISCARD->FETCH at redirect target.
REQ-028 redirect with ack in same cycle: returned word dropped, remain FETCH, next request at redirect_pc.
REQ-029 redirect during DISCARD: target replaced by newest redirect_pc, remain DISCARD.

Reset
REQ-030 Reset asserted: state=IDLE, fetch PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_pc=RESET_PC, if_instruction=NOP_INSN, if_valid=0, skid empty, counters 0.
REQ-031 Reset mid-request abandons the request; imem_ack while imem_req=0 is ignored.

Configuration
REQ-032 Macro IF_STAGE_PERF_CNT_EN defined: perf_fetch_cnt increments each cycle if_valid=1 and stall=0; perf_stall_cnt increments each cycle stall=1; both wrap at 2^32.
REQ-033 IF_STAGE_PERF_CNT_EN undefined: both perf outputs tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-034 Reset release, imem_ack tied 1, rdata=addr: addresses 0,4,8,...; if_valid=1 from cycle 2 each cycle, if_pc=0,4,8.
REQ-035 ack delayed 3 cycles at addr 0x8: imem_addr stays 0x8, if_valid=0/NOP_INSN for 3 cycles, then if_pc=0x8.
REQ-036 stall=1 for 2 cycles while ack arrives for 0xC: outputs hold previous instruction, 0xC captured in skid, delivered cycle after stall drops, no duplicate or loss.
REQ-037 redirect to 0x100 while 0x10 outstanding, ack 2 cycles later: 0x10 data never on if_instruction, next request addr 0x100, if_pc=0x100.
REQ-038 redirect and stall same cycle, redirect_pc=0x203: bubble output next edge, fetch resumes at 0x200.
REQ-039 With IF_STAGE_PERF_CNT_EN, 10 delivered instructions plus 3 stall cycles: perf_fetch_cnt=10, perf_stall_cnt=3; without macro both read 0.
